// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode-0 slave with a 16 x 8 register bank and local read port
module spi_reg_slave #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  input  logic [3:0] loc_addr,
  output logic [7:0] loc_rdata,
  output logic       wr_pulse,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_pulse,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_n;

  logic        ss_q1, ss_s, ss_d;
  logic        sck_q1, sck_s, sck_d;
  logic        mosi_q1, mosi_s;

  logic        sck_rise, sck_fall, ss_rise;
  logic        bit_rise;
  logic        cmd_done, data_done;

  logic [4:0]  cnt;
  logic [7:0]  rx_sr;
  logic [7:0]  rx_next;
  logic [7:0]  tx_sr;
  logic        rw_q;
  logic [3:0]  idx_q;

  logic [7:0]  bank [16];

  // Two-flop synchronisers for the SPI pins plus one extra stage for edge detection;
  // select resets high so a reset never looks like a frame start or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q1   <= 1'b1;
      ss_s    <= 1'b1;
      ss_d    <= 1'b1;
      sck_q1  <= 1'b0;
      sck_s   <= 1'b0;
      sck_d   <= 1'b0;
      mosi_q1 <= 1'b0;
      mosi_s  <= 1'b0;
    end else begin
      ss_q1   <= ss;
      ss_s    <= ss_q1;
      ss_d    <= ss_s;
      sck_q1  <= sck;
      sck_s   <= sck_q1;
      sck_d   <= sck_s;
      mosi_q1 <= mosi;
      mosi_s  <= mosi_q1;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign bit_rise = ~ss_s & sck_rise & (cnt < 5'd16);
  assign rx_next  = {rx_sr[6:0], mosi_s};

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode; also flags the rises that complete the command and data bytes.
  always_comb begin
    state_n   = state;
    cmd_done  = 1'b0;
    data_done = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_s) state_n = CMD;
      end
      CMD: begin
        if (ss_s) begin
          state_n = IDLE;
        end else if (bit_rise && cnt == 5'd7) begin
          state_n  = DATA;
          cmd_done = 1'b1;
        end
      end
      DATA: begin
        if (ss_s) begin
          state_n = IDLE;
        end else if (bit_rise && cnt == 5'd15) begin
          state_n   = DONE;
          data_done = 1'b1;
        end
      end
      DONE: begin
        if (ss_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit counter and receive shifter; counting stops at 16 so trailing clocks are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 5'd0;
      rx_sr <= 8'h00;
    end else if (ss_s) begin
      cnt <= 5'd0;
    end else if (bit_rise) begin
      cnt   <= cnt + 5'd1;
      rx_sr <= rx_next;
    end
  end

  // Command latch, read-data load and MSB-first transmit shifting on falling sck.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q     <= 1'b0;
      idx_q    <= 4'd0;
      tx_sr    <= 8'h00;
      rd_pulse <= 1'b0;
    end else begin
      rd_pulse <= 1'b0;
      if (cmd_done) begin
        rw_q  <= rx_next[7];
        idx_q <= rx_next[3:0];
        if (rx_next[7]) begin
          tx_sr    <= bank[rx_next[3:0]];
          rd_pulse <= 1'b1;
        end
      end else if (!ss_s && sck_fall && rw_q && cnt >= 5'd9 && cnt <= 5'd15) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

  assign miso = (!ss_s && rw_q && cnt >= 5'd8) ? tx_sr[7] : 1'b0;

  // Register bank with write commit on the sixteenth rise of a write frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bank[i] <= RESET_VAL;
      wr_pulse <= 1'b0;
      wr_addr  <= 4'd0;
      wr_data  <= 8'h00;
    end else begin
      wr_pulse <= 1'b0;
      if (data_done && !rw_q) begin
        bank[idx_q] <= rx_next;
        wr_addr     <= idx_q;
        wr_data     <= rx_next;
        wr_pulse    <= 1'b1;
      end
    end
  end

  // Abort detection: select released mid-frame (neither idle nor complete).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= ss_rise && (cnt != 5'd0) && (cnt != 5'd16);
    end
  end

  assign loc_rdata = bank[loc_addr];

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - directed bench for spi_reg_slave
module tb_spi_reg_slave;

  localparam int HALF = 8;

  logic       clk;
  logic       rst;
  logic       ss;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [3:0] loc_addr;
  logic [7:0] loc_rdata;
  logic       wr_pulse;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_pulse;
  logic       frame_err;

  int n_cmp;
  int n_bad;
  int wr_cnt;
  int rd_cnt;
  int err_cnt;
  int wr0, rd0, err0;
  logic [7:0] rdata;

  spi_reg_slave #(.RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .ss        (ss),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .loc_addr  (loc_addr),
    .loc_rdata (loc_rdata),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_pulse  (rd_pulse),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles each strobe is high; a strobe stuck high shows up as a count above one.
  always @(posedge clk) begin
    if (!rst) begin
      if (wr_pulse)  wr_cnt  = wr_cnt + 1;
      if (rd_pulse)  rd_cnt  = rd_cnt + 1;
      if (frame_err) err_cnt = err_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Mode-0 master: data set while sck low, miso sampled just before each rise.
  // Bits past 16 shift out ones so a slave that keeps counting would corrupt the commit.
  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                           output logic [7:0] rd);
    logic [15:0] word;
    word = {b0, b1};
    rd   = 8'h00;
    ss   = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? word[15 - i] : 1'b1;
      wait_clk(HALF);
      if (i >= 8 && i < 16) rd = {rd[6:0], miso};
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    ss   = 1'b1;
    mosi = 1'b0;
    wait_clk(10);
  endtask

  task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string tag);
    loc_addr = a;
    @(negedge clk);
    check(tag, {24'd0, loc_rdata}, {24'd0, exp});
  endtask

  task automatic snap();
    wr0  = wr_cnt;
    rd0  = rd_cnt;
    err0 = err_cnt;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    wr_cnt = 0; rd_cnt = 0; err_cnt = 0;
    rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; loc_addr = 4'd0;
    wait_clk(3);
    @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    check("rst_rd_pulse", {31'd0, rd_pulse}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    rst = 1'b0;
    wait_clk(5);
    peek(4'd5, 8'h00, "rst_bank5");

    // write 0x55 / 0xAA
    snap();
    spi_frame(8'h55, 8'hAA, 16, rdata);
    check("w1_wr_cnt", wr_cnt - wr0, 1);
    check("w1_wr_addr", {28'd0, wr_addr}, 32'd5);
    check("w1_wr_data", {24'd0, wr_data}, 32'hAA);
    check("w1_err_cnt", err_cnt - err0, 0);
    check("w1_rd_cnt", rd_cnt - rd0, 0);
    peek(4'd5, 8'hAA, "w1_bank5");

    // read back index 5
    snap();
    spi_frame(8'h85, 8'h00, 16, rdata);
    check("r1_rd_cnt", rd_cnt - rd0, 1);
    check("r1_rdata", {24'd0, rdata}, 32'hAA);
    check("r1_wr_cnt", wr_cnt - wr0, 0);
    check("r1_err_cnt", err_cnt - err0, 0);
    check("r1_idle_miso", {31'd0, miso}, 32'd0);

    // read unwritten index 15
    snap();
    spi_frame(8'h8F, 8'hFF, 16, rdata);
    check("r2_rd_cnt", rd_cnt - rd0, 1);
    check("r2_rdata", {24'd0, rdata}, 32'h00);
    peek(4'd15, 8'h00, "r2_bank15");
    peek(4'd5, 8'hAA, "r2_bank5");

    // write aborted after 12 bits
    snap();
    spi_frame(8'h03, 8'h3C, 12, rdata);
    check("ab_err_cnt", err_cnt - err0, 1);
    check("ab_wr_cnt", wr_cnt - wr0, 0);
    check("ab_wr_addr", {28'd0, wr_addr}, 32'd5);
    peek(4'd3, 8'h00, "ab_bank3");

    // write with 20 clocks before select released
    snap();
    spi_frame(8'h09, 8'hC3, 20, rdata);
    check("ov_wr_cnt", wr_cnt - wr0, 1);
    check("ov_wr_addr", {28'd0, wr_addr}, 32'd9);
    check("ov_wr_data", {24'd0, wr_data}, 32'hC3);
    check("ov_err_cnt", err_cnt - err0, 0);
    peek(4'd9, 8'hC3, "ov_bank9");

    // reset in the middle of a write frame
    snap();
    ss = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 10; i++) begin
      mosi = i[0];
      wait_clk(HALF);
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
    rst = 1'b1;
    wait_clk(2);
    ss = 1'b1;
    mosi = 1'b0;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(10);
    check("mr_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("mr_wr_data", {24'd0, wr_data}, 32'd0);
    peek(4'd5, 8'h00, "mr_bank5");
    peek(4'd9, 8'h00, "mr_bank9");
    check("mr_wr_cnt", wr_cnt - wr0, 0);
    check("mr_err_cnt", err_cnt - err0, 0);
    check("mr_rd_cnt", rd_cnt - rd0, 0);

    snap();
    spi_frame(8'h07, 8'h5A, 16, rdata);
    check("pr_wr_cnt", wr_cnt - wr0, 1);
    check("pr_wr_addr", {28'd0, wr_addr}, 32'd7);
    check("pr_wr_data", {24'd0, wr_data}, 32'h5A);
    check("pr_err_cnt", err_cnt - err0, 0);
    peek(4'd7, 8'h5A, "pr_bank7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
